// File: rtl/ultrasound_pkg.sv
// Shared types and constants for the ultrasonic ranging controller.
// Holds the FSM encoding, microsecond-to-cycle helpers and the filter length.
package ultrasound_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_GAP
  } state_t;

  localparam int unsigned FILT_LEN = 3;

  function automatic int unsigned us_to_cyc(input int unsigned hz, input int unsigned us);
    return 32'((64'(hz) * 64'(us)) / 64'd1_000_000);
  endfunction

  // Sound round trip is ~58 us per centimetre of range.
  function automatic int unsigned cyc_per_cm(input int unsigned hz);
    return us_to_cyc(hz, 58);
  endfunction

endpackage

// File: rtl/ultrasound_array_echo_sync.sv
// Two-flop synchroniser for one echo pin plus an edge register.
// rise/fall are single-cycle pulses, three cycles after the pin edge.
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic echo,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;

  always_comb begin
    s1_d = echo;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/ultrasound_array.sv
// Round-robin multi-channel HC-SR04 ranging: trigger, echo timing, cm conversion, proximity flags.
// Define ULTRASOUND_FILTER_EN to add a 3-publish hysteresis on each object_detected bit.
module ultrasound_array
  import ultrasound_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned N_CH         = 2,
  parameter int unsigned DIST_W       = 9,
  parameter int unsigned TRIG_US      = 10,
  parameter int unsigned ECHO_WAIT_US = 30_000,
  parameter int unsigned MAX_CM       = 400,
  parameter int unsigned DETECT_CM    = 20,
  parameter int unsigned GAP_US       = 60_000
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start_en,
  input  logic [N_CH-1:0]                          echo,
  output logic [N_CH-1:0]                          trigger,
  output logic [N_CH-1:0]                          object_detected,
  output logic [DIST_W-1:0]                        distance_cm,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] dist_ch,
  output logic                                     dist_valid,
  output logic                                     timeout
);

  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned TRIG_CYC   = us_to_cyc(CLK_FREQ_HZ, TRIG_US);
  localparam int unsigned WAIT_CYC   = us_to_cyc(CLK_FREQ_HZ, ECHO_WAIT_US);
  localparam int unsigned GAP_CYC    = us_to_cyc(CLK_FREQ_HZ, GAP_US);
  localparam int unsigned CYC_PER_CM = cyc_per_cm(CLK_FREQ_HZ);
  localparam int unsigned TMR_MAX    = (TRIG_CYC > WAIT_CYC) ?
                                       ((TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC) :
                                       ((WAIT_CYC > GAP_CYC) ? WAIT_CYC : GAP_CYC);
  localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);
  localparam int unsigned PRE_W      = $clog2(CYC_PER_CM + 1);

  logic [N_CH-1:0] rise, fall;

  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    echo_sync u_echo_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .echo  (echo[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, dch_q, dch_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DIST_W-1:0] cm_q, cm_d, dist_q, dist_d;
  logic [N_CH-1:0]   trigger_q, trigger_d, det_q, det_d;
  logic              vld_q, vld_d, to_q, to_d;

  logic              pub, pub_to, raw_near, pre_wrap;
  logic [DIST_W-1:0] pub_cm, cm_inc;

`ifdef ULTRASOUND_FILTER_EN
  logic [N_CH-1:0][1:0] filt_q, filt_d;
`endif

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    tmr_d    = '0;
    pre_d    = pre_q;
    cm_d     = cm_q;
    pub      = 1'b0;
    pub_to   = 1'b0;
    pub_cm   = '0;
    pre_wrap = (pre_q == PRE_W'(CYC_PER_CM - 1));
    cm_inc   = pre_wrap ? cm_q + 1'b1 : cm_q;

    case (state_q)
      ST_IDLE: begin
        if (start_en) state_d = ST_TRIG;
      end
      ST_TRIG: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TMR_W'(TRIG_CYC - 1)) begin
          state_d = ST_WAIT_ECHO;
          tmr_d   = '0;
        end
      end
      ST_WAIT_ECHO: begin
        tmr_d = tmr_q + 1'b1;
        if (rise[ch_q]) begin
          state_d = ST_MEASURE;
          pre_d   = '0;
          cm_d    = '0;
        end else if (tmr_q == TMR_W'(WAIT_CYC - 1)) begin
          pub     = 1'b1;
          pub_to  = 1'b1;
          pub_cm  = DIST_W'(MAX_CM);
          state_d = ST_GAP;
          tmr_d   = '0;
        end
      end
      ST_MEASURE: begin
        // The publish cycle itself is counted so rise/fall latencies cancel exactly.
        pre_d = pre_wrap ? '0 : pre_q + 1'b1;
        cm_d  = cm_inc;
        if (cm_inc >= DIST_W'(MAX_CM)) begin
          pub     = 1'b1;
          pub_to  = 1'b1;
          pub_cm  = DIST_W'(MAX_CM);
          state_d = ST_GAP;
        end else if (fall[ch_q]) begin
          pub     = 1'b1;
          pub_cm  = cm_inc;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TMR_W'(GAP_CYC - 1)) begin
          ch_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
          state_d = start_en ? ST_TRIG : ST_IDLE;
          tmr_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    trigger_d = '0;
    if (state_d == ST_TRIG) trigger_d[ch_d] = 1'b1;

    vld_d    = pub;
    to_d     = pub & pub_to;
    dist_d   = pub ? pub_cm : dist_q;
    dch_d    = pub ? ch_q : dch_q;
    det_d    = det_q;
    raw_near = !pub_to && (pub_cm < DIST_W'(DETECT_CM));
`ifdef ULTRASOUND_FILTER_EN
    filt_d = filt_q;
    if (pub) begin
      if (raw_near == det_q[ch_q]) begin
        filt_d[ch_q] = '0;
      end else if (filt_q[ch_q] == 2'(FILT_LEN - 1)) begin
        det_d[ch_q]  = raw_near;
        filt_d[ch_q] = '0;
      end else begin
        filt_d[ch_q] = filt_q[ch_q] + 1'b1;
      end
    end
`else
    if (pub) det_d[ch_q] = raw_near;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      tmr_q     <= '0;
      pre_q     <= '0;
      cm_q      <= '0;
      trigger_q <= '0;
      det_q     <= '0;
      dist_q    <= '0;
      dch_q     <= '0;
      vld_q     <= 1'b0;
      to_q      <= 1'b0;
`ifdef ULTRASOUND_FILTER_EN
      filt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      tmr_q     <= tmr_d;
      pre_q     <= pre_d;
      cm_q      <= cm_d;
      trigger_q <= trigger_d;
      det_q     <= det_d;
      dist_q    <= dist_d;
      dch_q     <= dch_d;
      vld_q     <= vld_d;
      to_q      <= to_d;
`ifdef ULTRASOUND_FILTER_EN
      filt_q    <= filt_d;
`endif
    end
  end

  assign trigger         = trigger_q;
  assign object_detected = det_q;
  assign distance_cm     = dist_q;
  assign dist_ch         = dch_q;
  assign dist_valid      = vld_q;
  assign timeout         = to_q;

endmodule

// File: tb/tb_ultrasound_array.sv
// Randomized scoreboard bench for ultrasound_array: stimulus pushes expected publishes,
// a negedge monitor pops and compares them whenever dist_valid is seen.
module tb_ultrasound_array;

  localparam int N_CH      = 2;
  localparam int DIST_W    = 9;
  localparam int CPC       = 58;
  localparam int MAX_CM    = 400;
  localparam int DETECT_CM = 20;
  localparam int TRIG_CYC  = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_en = 1'b0;
  logic [N_CH-1:0]   echo = '0;
  logic [N_CH-1:0]   trigger;
  logic [N_CH-1:0]   object_detected;
  logic [DIST_W-1:0] distance_cm;
  logic [0:0]        dist_ch;
  logic              dist_valid;
  logic              timeout;

  always #5 clk = ~clk;

  ultrasound_array #(
    .CLK_FREQ_HZ  (1_000_000),
    .N_CH         (N_CH),
    .DIST_W       (DIST_W),
    .TRIG_US      (10),
    .ECHO_WAIT_US (1000),
    .MAX_CM       (MAX_CM),
    .DETECT_CM    (DETECT_CM),
    .GAP_US       (100)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_en        (start_en),
    .echo            (echo),
    .trigger         (trigger),
    .object_detected (object_detected),
    .distance_cm     (distance_cm),
    .dist_ch         (dist_ch),
    .dist_valid      (dist_valid),
    .timeout         (timeout)
  );

  typedef struct {
    int              cm;
    bit              to;
    int              ch;
    logic [N_CH-1:0] det;
  } exp_t;

  typedef enum int {A_ECHO, A_NONE, A_HELD, A_STUCK, A_RESET, A_STOP} act_t;

  exp_t          exp_q[$];
  exp_t          cur;
  act_t          act_q[$];
  int            len_q[$];
  int            compared = 0;
  int            mismatched = 0;
  int            exp_ch = 0;
  bit [N_CH-1:0] model_det = '0;
  int            disagree_run[N_CH];

  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: a flag follows the near/far verdict, optionally only after 3 disagreeing publishes in a row.
  function automatic void model_publish(input int ch, input int cm, input bit to);
    bit near;
    exp_t e;
    near = !to && (cm < DETECT_CM);
`ifdef ULTRASOUND_FILTER_EN
    if (near != model_det[ch]) begin
      disagree_run[ch]++;
      if (disagree_run[ch] == 3) begin
        model_det[ch]    = near;
        disagree_run[ch] = 0;
      end
    end else begin
      disagree_run[ch] = 0;
    end
`else
    model_det[ch] = near;
`endif
    e.cm  = cm;
    e.to  = to;
    e.ch  = ch;
    e.det = model_det;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (dist_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_publish", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("distance_cm", distance_cm, cur.cm);
          check("dist_ch", dist_ch, cur.ch);
          check("timeout", timeout, cur.to);
          check("object_detected", object_detected, cur.det);
        end
      end else if (timeout) begin
        check("timeout_without_valid", timeout, 0);
      end
    end
  end

  task automatic add(input act_t a, input int n);
    act_q.push_back(a);
    len_q.push_back(n);
  endtask

  task automatic add_rand();
    if ($urandom_range(0, 3) == 0) add(A_NONE, 0);
    else add(A_ECHO, $urandom_range(100, 2400));
  endtask

  task automatic run_step(input act_t a, input int n);
    int ch, w, d;
    bit bad;
    if (a == A_HELD) echo[exp_ch] = 1'b1;
    w = 0;
    while (trigger == '0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("trigger_seen", trigger != '0, 1);
    if (trigger == '0) $fatal(1, "no trigger, cannot continue");
    ch = trigger[1] ? 1 : 0;
    check("trigger_channel", ch, exp_ch);
    w = 0;
    bad = 1'b0;
    while (trigger[ch] && w < 50) begin
      if (trigger != (2'b01 << ch)) bad = 1'b1;
      w++;
      @(negedge clk);
    end
    check("trigger_width", w, TRIG_CYC);
    check("trigger_exclusive", bad, 0);

    d = $urandom_range(2, 20);
    case (a)
      A_ECHO, A_STOP: begin
        if (a == A_STOP) start_en = 1'b0;
        model_publish(exp_ch, n / CPC, 1'b0);
        repeat (d) @(negedge clk);
        echo[ch] = 1'b1;
        repeat (n) @(negedge clk);
        echo[ch] = 1'b0;
      end
      A_NONE: model_publish(exp_ch, MAX_CM, 1'b1);
      A_HELD: begin
        model_publish(exp_ch, MAX_CM, 1'b1);
        repeat (1050) @(negedge clk);
        echo[ch] = 1'b0;
      end
      A_STUCK: begin
        model_publish(exp_ch, MAX_CM, 1'b1);
        repeat (d) @(negedge clk);
        echo[ch] = 1'b1;
        repeat (MAX_CM * CPC + 60) @(negedge clk);
        echo[ch] = 1'b0;
      end
      A_RESET: begin
        repeat (d) @(negedge clk);
        echo[ch] = 1'b1;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_reset_trigger", trigger, 0);
        check("mid_reset_object_detected", object_detected, 0);
        check("mid_reset_distance_cm", distance_cm, 0);
        check("mid_reset_dist_ch", dist_ch, 0);
        check("mid_reset_dist_valid", dist_valid, 0);
        check("mid_reset_timeout", timeout, 0);
        echo = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        model_det = '0;
        foreach (disagree_run[i]) disagree_run[i] = 0;
        exp_ch = 0;
        return;
      end
      default: ;
    endcase
    exp_ch = (exp_ch + 1) % N_CH;

    if (a == A_STOP) begin
      w = 0;
      repeat (600) begin
        @(negedge clk);
        if (trigger != '0) w++;
      end
      check("no_trigger_after_stop", w, 0);
    end
  endtask

  initial begin
    int fseq[8];
    fseq = '{580, 580, 580, 2900, 580, 2900, 2900, 2900};
    foreach (disagree_run[i]) disagree_run[i] = 0;

    add(A_ECHO, 580);
    add(A_ECHO, 2900);
    add(A_NONE, 0);
    add_rand();
    add(A_HELD, 0);
    add_rand();
    foreach (fseq[i]) begin
      add(A_ECHO, fseq[i]);
      add_rand();
    end
    add(A_STUCK, 0);
    add(A_RESET, 0);
    add(A_ECHO, $urandom_range(100, 2400));
    add(A_STOP, $urandom_range(100, 2400));

    start_en = 1'b1;
    echo     = 2'b11;
    repeat (3) @(negedge clk);
    check("reset_trigger", trigger, 0);
    check("reset_object_detected", object_detected, 0);
    check("reset_distance_cm", distance_cm, 0);
    check("reset_dist_ch", dist_ch, 0);
    check("reset_dist_valid", dist_valid, 0);
    check("reset_timeout", timeout, 0);
    echo = '0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (act_q[i]) run_step(act_q[i], len_q[i]);

    check("pending_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: run exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ultrasound_array.md
# ultrasound_array

Parametrised multi-channel ultrasonic ranging controller for HC-SR04-class sensors. Fires each channel's trigger in round-robin order and times the returned echo pulse. Converts the pulse width to centimetres and raises a per-channel proximity flag. Sits between the sensor pins and the pet-interaction logic, replacing single-sensor, single-threshold detection with N channels, distance output and timeout reporting.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency
- `N_CH`, 2, number of sensor channels (1..8)
- `DIST_W`, 9, width of the distance output in cm
- `TRIG_US`, 10, trigger pulse width in µs
- `ECHO_WAIT_US`, 30_000, maximum wait for the echo rising edge after the trigger falls
- `MAX_CM`, 400, saturation distance; reaching it counts as a timeout
- `DETECT_CM`, 20, object-present threshold (strictly less than)
- `GAP_US`, 60_000, idle gap after each measurement, before the next channel fires
- `clk  in  1  system clock, rising edge`
- `rst_n  in  1  asynchronous, active-low reset`
- `start_en  in  1  level; 1 = keep scanning, 0 = stop after the current measurement`
- `echo  in  N_CH  raw asynchronous echo inputs`
- `trigger  out  N_CH  trigger outputs, at most one high at a time`
- `object_detected  out  N_CH  registered per-channel proximity flag`
- `distance_cm  out  DIST_W  last measured distance`
- `dist_ch  out  $clog2(N_CH) (min 1)  channel of distance_cm`
- `dist_valid  out  1  one-cycle strobe when a new distance is published`
- `timeout  out  1  one-cycle strobe, coincident with dist_valid, on a timeout`

## Operation
- `echo` is passed through a 2-flop synchroniser per channel. Only the active channel's synchronised echo is used; all other channels are ignored.
- Derived constants:
  - TRIG_CYC = CLK_FREQ_HZ/1e6·TRIG_US
  - CYC_PER_CM = CLK_FREQ_HZ·58/1e6
  - WAIT_CYC and GAP_CYC are derived the same way from their µs values
- FSM states:
  - IDLE: outputs quiet. When start_en=1, go to TRIG.
  - TRIG: trigger[ch]=1 for TRIG_CYC cycles, then go to WAIT_ECHO.
  - WAIT_ECHO: wait for a synchronised rising edge (0→1), not a level. An echo already high on entry is ignored until it falls and rises again. If WAIT_CYC expires first, publish a timeout and go to GAP.
  - MEASURE: a prescaler counts CYC_PER_CM; each wrap increments cm_cnt.
    - Synchronised falling edge: publish distance = cm_cnt, go to GAP.
    - cm_cnt reaches MAX_CM first: publish MAX_CM with timeout, go to GAP.
  - GAP: wait GAP_CYC cycles, then advance ch = (ch+1) mod N_CH. Go to TRIG if start_en=1, otherwise IDLE.
- Publish: in the same cycle as dist_valid=1, distance_cm, dist_ch, timeout and object_detected[ch] are all updated. Without the filter, the raw flag is (!timeout && distance < DETECT_CM). Other channels' flags hold.
- cm_cnt is DIST_W wide and saturates at MAX_CM; it never wraps. The prescaler resets on entry to MEASURE.
- start_en dropping mid-measurement does not abort the measurement: it completes, including GAP.
- Reset (any time, including mid-measurement) asynchronously sets:
  - FSM = IDLE, ch = 0
  - trigger, object_detected, distance_cm, dist_ch, dist_valid, timeout all 0
  - all counters and filter counters cleared

## Timing
- Trigger rises 1 cycle after start_en is sampled high in IDLE and stays high exactly TRIG_CYC cycles.
- Echo-edge detection latency: 3 cycles from the pin edge (2 synchroniser cycles plus 1 edge register).
- dist_valid asserts 1 cycle after the falling edge is detected, or in the cycle the timeout condition is reached.
- Measurement error: ±1 cm plus synchroniser skew. Rise and fall latencies are equal and cancel.
- Scan period per channel: TRIG_CYC + echo time + GAP_CYC + 2 cycles of FSM overhead.

## Configuration
- `ULTRASOUND_FILTER_EN` defined: each channel has a 2-bit consecutive counter.
  - object_detected[ch] sets only after 3 consecutive near publishes on that channel.
  - It clears only after 3 consecutive far or timeout publishes.
  - A publish that agrees with the current flag resets the counter.
- Not defined: object_detected[ch] equals the raw flag at every publish. No filter registers are present.

## Structure
- The shared package `ultrasound_pkg` holds:
  - the FSM state encoding (IDLE, TRIG, WAIT_ECHO, MEASURE, GAP)
  - the derived-cycle-constant functions
  - the filter length constant (3)
- One sub-module, `echo_sync`: a per-channel 2-flop synchroniser with rise/fall edge outputs, instantiated N_CH-wide.

## Test plan
Simulation parameters for all scenarios: CLK_FREQ_HZ=1_000_000 (CYC_PER_CM=58), N_CH=2, ECHO_WAIT_US=1000, GAP_US=100, DETECT_CM=20, MAX_CM=400.
- Reset: hold rst_n=0 with start_en=1 and echo=2'b11 → every output is 0. Release reset → trigger[0] is high for exactly 10 cycles and trigger[1] stays 0.
- Ch0 echo high for 580 cycles → dist_valid pulse with distance_cm=10, dist_ch=0, timeout=0, object_detected[0]=1 (filter off).
- Ch1 echo high for 2900 cycles → distance_cm=50, dist_ch=1, object_detected[1]=0, object_detected[0] still 1.
- No echo on ch0 → after 1000 cycles in WAIT_ECHO: dist_valid=1, timeout=1, distance_cm=400, object_detected[0]=0. Next, echo held high before the trigger → same timeout result (rising edge is required).
- Echo stuck high after a valid rise → distance_cm saturates at 400 with a timeout strobe. Assert rst_n low mid-MEASURE → outputs 0 immediately and the next trigger goes to ch0.
- With ULTRASOUND_FILTER_EN and a 10 cm echo on ch0:
  - object_detected[0] is 0 after publishes 1–2 and becomes 1 at the third.
  - One 50 cm publish keeps it 1.
  - Three consecutive 50 cm publishes clear it.
